lv_efuse_loader: RTL



---
 rtl/lv_efuse_loader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/lv_efuse_loader.sv
// lv_efuse_loader: eFuse load responder on the LV die.
// Handles the load request from the LV control FSM: powers up the macro, reads
// EFUSE_WORD_NUM words into a shadow image, then checks the image and reports
// load_done / efuse_vld.
// Build option: define LV_EFUSE_CHKSUM_EN to also require the last word to
// equal the XOR of all preceding words before the image is reported valid.
module lv_efuse_loader #(
  parameter int                      EFUSE_WORD_NUM = 8,
  parameter int                      EFUSE_DATA_W   = 8,
  parameter int                      EFUSE_ADDR_W   = 3,
  parameter int                      EFUSE_RD_LAT   = 2,
  parameter int                      EFUSE_PWUP_DLY = 4,
  parameter logic [EFUSE_DATA_W-1:0] EFUSE_MARK     = 8'hA5
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_efuse_load_req,
  output logic                                   o_efuse_load_done,
  output logic                                   o_efuse_vld,
  output logic                                   o_efuse_busy,
  output logic                                   o_efuse_pwr_en,
  output logic                                   o_efuse_rd_en,
  output logic [EFUSE_ADDR_W-1:0]                o_efuse_addr,
  input  logic [EFUSE_DATA_W-1:0]                i_efuse_rdata,
  output logic [EFUSE_WORD_NUM*EFUSE_DATA_W-1:0] o_efuse_data
);

  // One counter serves both the power-up settle and the read-latency wait.
  localparam int CNT_MAX = (EFUSE_PWUP_DLY > EFUSE_RD_LAT) ? EFUSE_PWUP_DLY : EFUSE_RD_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]        PWUP_LAST = CNT_W'(EFUSE_PWUP_DLY - 1);
  localparam logic [CNT_W-1:0]        WAIT_LAST = CNT_W'(EFUSE_RD_LAT - 1);
  localparam logic [EFUSE_ADDR_W-1:0] IDX_LAST  = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PWUP, S_READ, S_WAIT, S_CHK, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [EFUSE_ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    vld_q, vld_d;
  logic                    cap;
  logic                    chk_ok;
  logic [EFUSE_DATA_W-1:0] word_q [EFUSE_WORD_NUM];

`ifdef LV_EFUSE_CHKSUM_EN
  logic [EFUSE_DATA_W-1:0] xor_acc;

  // Running XOR of every word except the last (the stored checksum).
  always_comb begin
    xor_acc = '0;
    for (int k = 0; k < EFUSE_WORD_NUM - 1; k++) begin
      xor_acc = xor_acc ^ word_q[k];
    end
  end

  assign chk_ok = (word_q[0] == EFUSE_MARK) && (word_q[EFUSE_WORD_NUM-1] == xor_acc);
`else
  assign chk_ok = (word_q[0] == EFUSE_MARK);
`endif

  // State, word index, shared counter and valid flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  // Next-state logic; dropping the request anywhere mid-load aborts to IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    cap     = 1'b0;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (i_efuse_load_req) begin
          state_d = S_PWUP;
          vld_d   = 1'b0;
        end
      end
      S_PWUP: begin
        if (!i_efuse_load_req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == PWUP_LAST) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READ: begin
        cnt_d   = '0;
        state_d = i_efuse_load_req ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (!i_efuse_load_req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WAIT_LAST) begin
          cap   = 1'b1;
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_CHK;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_READ;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHK: begin
        if (!i_efuse_load_req) begin
          state_d = S_IDLE;
          vld_d   = 1'b0;
        end else begin
          state_d = S_DONE;
          vld_d   = chk_ok;
        end
      end
      S_DONE: begin
        if (!i_efuse_load_req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shadow image: capture the addressed word at the end of its last wait cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < EFUSE_WORD_NUM; k++) begin
        word_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < EFUSE_WORD_NUM; k++) begin
        if (cap && (idx_q == EFUSE_ADDR_W'(k))) begin
          word_q[k] <= i_efuse_rdata;
        end
      end
    end
  end

  for (genvar gi = 0; gi < EFUSE_WORD_NUM; gi++) begin : g_data
    assign o_efuse_data[gi*EFUSE_DATA_W +: EFUSE_DATA_W] = word_q[gi];
  end

  assign o_efuse_load_done = (state_q == S_DONE);
  assign o_efuse_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_efuse_pwr_en    = (state_q == S_PWUP) || (state_q == S_READ) || (state_q == S_WAIT);
  assign o_efuse_rd_en     = (state_q == S_READ);
  assign o_efuse_addr      = idx_q;
  assign o_efuse_vld       = vld_q;

endmodule
